// File: rtl/locked_reg_pkg.sv
// Shared types and constants for the lockable register bank and its debug-unlock FSM.
package locked_reg_pkg;

  typedef enum logic [1:0] {
    CLOSED,
    CHECK,
    OPEN,
    BLOCKED
  } dbg_state_t;

  localparam int MAX_KEY_FAILS = 3;
  localparam int VIOL_CNT_W    = 8;
  localparam int FAIL_CNT_W    = $clog2(MAX_KEY_FAILS + 1);

  // Address width for a bank of n registers, never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbg_unlock_fsm.sv
// Debug unlock controller: key check, timed open window, and a lockout after repeated bad keys.
module dbg_unlock_fsm
  import locked_reg_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] DBG_KEY    = DATA_W'(16'hA5C3),
  parameter int                DBG_WINDOW = 64
) (
  input  logic              Clk,
  input  logic              resetn,
  input  logic              scan_mode,
  input  logic              dbg_req,
  input  logic [DATA_W-1:0] dbg_key,
  output logic              dbg_open
);

  localparam int                 TIMER_W     = $clog2(DBG_WINDOW + 1);
  localparam logic [TIMER_W-1:0] WINDOW_LOAD = TIMER_W'(DBG_WINDOW);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

  dbg_state_t            state;
  dbg_state_t            state_nxt;
  logic [DATA_W-1:0]     key_q;
  logic [TIMER_W-1:0]    timer;
  logic [FAIL_CNT_W-1:0] fail_cnt;
  logic                  key_match;
  logic                  last_fail;

  assign key_match = (key_q == DBG_KEY);
  assign last_fail = (fail_cnt == FAIL_CNT_W'(MAX_KEY_FAILS - 1));

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state    <= CLOSED;
      key_q    <= '0;
      timer    <= '0;
      fail_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLOSED && dbg_req && !scan_mode) begin
        key_q <= dbg_key;
      end
      if (state == CHECK && state_nxt == OPEN) begin
        timer <= WINDOW_LOAD;
      end else if (state == OPEN) begin
        timer <= timer - TIMER_ONE;
      end
      if (state == CHECK && !scan_mode && !key_match) begin
        fail_cnt <= fail_cnt + FAIL_CNT_W'(1);
      end
    end
  end

  // NOTE: state_nxt gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      CLOSED:  if (dbg_req) state_nxt = CHECK;
      CHECK: begin
        if (key_match)      state_nxt = OPEN;
        else if (last_fail) state_nxt = BLOCKED;
        else                state_nxt = CLOSED;
      end
      OPEN:    if (timer == TIMER_ONE) state_nxt = CLOSED;
      BLOCKED: state_nxt = BLOCKED;
      default: state_nxt = CLOSED;
    endcase
    // Scan always drops an open or pending session, but cannot lift a lockout.
    if (scan_mode && state != BLOCKED) begin
      state_nxt = CLOSED;
    end
  end

  always_comb begin
    dbg_open = (state == OPEN);
  end

endmodule

// File: rtl/locked_reg_bank.sv
// Bank of sticky-lockable registers with registered read port, write status pulses,
// lock-violation counter and a key-gated debug window that bypasses locks.
module locked_reg_bank
  import locked_reg_pkg::*;
#(
  parameter int                NUM_REGS   = 8,
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] DBG_KEY    = DATA_W'(16'hA5C3),
  parameter int                DBG_WINDOW = 64,
  localparam int               ADDR_W     = addr_width(NUM_REGS)
) (
  input  logic                  Clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  lock_set,
  input  logic [ADDR_W-1:0]     lock_addr,
  input  logic                  lock_all,
  input  logic                  scan_mode,
  input  logic                  dbg_req,
  input  logic [DATA_W-1:0]     dbg_key,
  output logic                  dbg_open,
  output logic                  wr_ok,
  output logic                  wr_err,
  output logic [NUM_REGS-1:0]   lock_status,
  output logic [VIOL_CNT_W-1:0] viol_cnt
);

  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              unlock;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_locked;
  logic              wr_commit;
  logic              wr_lock_reject;
  logic              rd_masked;

  // One extra bit keeps the compare meaningful when NUM_REGS is a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < REG_LIMIT;
  endfunction

  dbg_unlock_fsm #(
    .DATA_W     (DATA_W),
    .DBG_KEY    (DBG_KEY),
    .DBG_WINDOW (DBG_WINDOW)
  ) u_dbg (
    .Clk       (Clk),
    .resetn    (resetn),
    .scan_mode (scan_mode),
    .dbg_req   (dbg_req),
    .dbg_key   (dbg_key),
    .dbg_open  (dbg_open)
  );

  // The debug window never bypasses a lock while scan is asserted, even in the
  // cycle before the FSM has been forced closed.
  assign unlock      = dbg_open && !scan_mode;
  assign wr_in_range = in_range(wr_addr);
  assign rd_in_range = in_range(rd_addr);

  // Same-cycle lock requests count as already locked: lock wins over write.
  assign wr_locked = lock_all
                  || (lock_set && lock_addr == wr_addr)
                  || (wr_in_range && lock_status[wr_addr]);

  assign wr_commit      = wr_en && wr_in_range && (!wr_locked || unlock);
  assign wr_lock_reject = wr_en && wr_in_range && wr_locked && !unlock;
  assign rd_masked      = !rd_in_range || (scan_mode && lock_status[rd_addr]);

  // NOTE: the array sits on the async reset like every other flop, so a reset can never leave old contents readable.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      lock_status <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (lock_all || (lock_set && lock_addr == ADDR_W'(i))) begin
          lock_status[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      wr_ok    <= 1'b0;
      wr_err   <= 1'b0;
      viol_cnt <= '0;
    end else begin
      wr_ok  <= wr_commit;
      wr_err <= wr_en && !wr_commit;
      if (wr_lock_reject && viol_cnt != '1) begin
        viol_cnt <= viol_cnt + VIOL_CNT_W'(1);
      end
    end
  end

  // Read samples the pre-edge array, so a same-cycle write is not visible yet.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_masked ? '0 : regs[rd_addr];
      end
    end
  end

endmodule
